// File: rtl/ext_timer_pkg.sv
// rtl/ext_timer_pkg.sv - register map and bit positions for the EXT bus timer/compare peripheral
package ext_timer_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COMPARE  = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd5;

    localparam int CTRL_W    = 3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_MATCH = 0;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running 0..limit divider producing a one-cycle tick
module timer_prescaler #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    input  logic [PW-1:0] limit,
    output logic          tick
);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;
    logic          at_limit;

    assign at_limit = (pre_cnt_q == limit);
    // A clear in the same cycle swallows the tick that would otherwise fire.
    assign tick     = enable & ~clear & at_limit;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clear) begin
            pre_cnt_d = '0;
        end else if (enable) begin
            pre_cnt_d = at_limit ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/ext_timer.sv
// rtl/ext_timer.sv - prescaled 32-bit up-counter with compare match, auto-reload, capture and level irq
module ext_timer
    import ext_timer_pkg::*;
#(
    parameter int CW = 32,
    parameter int PW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  addr,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CW-1:0]     cmp_q, cmp_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     cap_q, cap_d;
    logic              match_q, match_d;
    logic              irq_q, irq_d;
    logic [31:0]       dout_q, dout_d;
    logic [31:0]       rdata;

    logic wr, rd;
    logic wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status, wr_cap;
    logic tick, hit;

    assign wr        = en & we;
    assign rd        = en & ~we;
    assign wr_ctrl   = wr && (addr == ADDR_CTRL);
    assign wr_presc  = wr && (addr == ADDR_PRESCALE);
    assign wr_cmp    = wr && (addr == ADDR_COMPARE);
    assign wr_count  = wr && (addr == ADDR_COUNT);
    assign wr_status = wr && (addr == ADDR_STATUS);
    assign wr_cap    = wr && (addr == ADDR_CAPTURE);

    // Loading COUNT or PRESCALE restarts the divider so the next increment is a full period away.
    timer_prescaler #(.PW(PW)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (ctrl_q[CTRL_EN]),
        .clear  (wr_presc | wr_count),
        .limit  (presc_q),
        .tick   (tick)
    );

    assign hit = tick && (count_q == cmp_q);

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:     rdata = 32'(ctrl_q);
            ADDR_PRESCALE: rdata = 32'(presc_q);
            ADDR_COMPARE:  rdata = 32'(cmp_q);
            ADDR_COUNT:    rdata = 32'(count_q);
            ADDR_STATUS:   rdata = 32'(match_q);
            ADDR_CAPTURE:  rdata = 32'(cap_q);
            default:       rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d  = wr_ctrl  ? din[CTRL_W-1:0] : ctrl_q;
        presc_d = wr_presc ? din[PW-1:0]     : presc_q;
        cmp_d   = wr_cmp   ? din[CW-1:0]     : cmp_q;
        cap_d   = wr_cap   ? count_q         : cap_q;
        dout_d  = rd       ? rdata           : dout_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = din[CW-1:0];
        end else if (tick) begin
            count_d = (hit && ctrl_q[CTRL_AUTO]) ? '0 : count_q + 1'b1;
        end

        // A match in the same cycle as a W1C clear wins.
        match_d = match_q;
        if (hit) begin
            match_d = 1'b1;
        end else if (wr_status && din[STAT_MATCH]) begin
            match_d = 1'b0;
        end

        irq_d = match_d & ctrl_d[CTRL_IE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            cap_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            cap_q   <= cap_d;
            match_q <= match_d;
            irq_q   <= irq_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_ext_timer.sv
// tb/tb_ext_timer.sv - directed and randomized checks of ext_timer against a register-level reference model
module tb_ext_timer;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic        en;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_cmp;
    int n_bad;

    // Reference state, kept as the programmer-visible registers plus the divider phase.
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    logic [15:0] m_phase;
    logic [31:0] m_cmp;
    logic [31:0] m_cnt;
    logic [31:0] m_cap;
    logic        m_match;
    logic        m_irq;
    logic [31:0] m_dout;

    ext_timer #(.CW(32), .PW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .en   (en),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_presc = '0; m_phase = '0; m_cmp = '0; m_cnt = '0;
        m_cap = '0; m_match = 1'b0; m_irq = 1'b0; m_dout = '0;
    endtask

    task automatic model_step(input bit e, input bit w, input logic [2:0] a, input logic [31:0] d);
        bit          wr_cnt, wr_pre, tick, hit;
        logic [31:0] regs [8];
        regs[0] = {29'd0, m_ctrl};
        regs[1] = {16'd0, m_presc};
        regs[2] = m_cmp;
        regs[3] = m_cnt;
        regs[4] = {31'd0, m_match};
        regs[5] = m_cap;
        regs[6] = '0;
        regs[7] = '0;
        if (e && !w) m_dout = regs[a];

        wr_cnt = e && w && (a == 3'd3);
        wr_pre = e && w && (a == 3'd1);
        tick   = m_ctrl[0] && (m_phase == m_presc) && !wr_cnt && !wr_pre;
        hit    = tick && (m_cnt == m_cmp);

        if (wr_cnt || wr_pre)  m_phase = '0;
        else if (m_ctrl[0])    m_phase = (m_phase == m_presc) ? 16'd0 : m_phase + 16'd1;

        if (e && w && a == 3'd5) m_cap = m_cnt;
        if (wr_cnt)              m_cnt = d;
        else if (hit && m_ctrl[1]) m_cnt = 32'd0;
        else if (tick)           m_cnt = m_cnt + 32'd1;

        if (hit)                                 m_match = 1'b1;
        else if (e && w && a == 3'd4 && d[0])    m_match = 1'b0;

        if (e && w && a == 3'd0) m_ctrl  = d[2:0];
        if (wr_pre)              m_presc = d[15:0];
        if (e && w && a == 3'd2) m_cmp   = d;
        m_irq = m_match & m_ctrl[2];
    endtask

    // One bus cycle: drive at negedge, clock, then compare outputs at the following negedge.
    task automatic cyc(input bit e, input bit w, input logic [2:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; din = d;
        @(posedge clk);
        model_step(e, w, a, d);
        @(negedge clk);
        en = 1'b0; we = 1'b0;
        check("dout", dout, m_dout);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        en = 1'b0; we = 1'b0; addr = '0; din = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("reset_read", dout, 32'd0);
        end

        // Prescale 3: increments at every fourth edge; disabling freezes COUNT.
        wr(3'd1, 32'd3);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd0, 32'd1);
        idle(40);
        rd(3'd3);
        check("prescale_count", dout, 32'd10);
        wr(3'd0, 32'd0);
        idle(20);
        rd(3'd3);
        check("disabled_hold", dout, 32'd10);

        // Auto-reload with interrupt.
        pulse_reset();
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'd7);
        idle(5);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_after_match", {31'd0, irq}, 32'd1);
        wr(3'd4, 32'd1);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        idle(4);
        check("irq_still_low", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_second_match", {31'd0, irq}, 32'd1);
        idle(5);
        wr(3'd4, 32'd1);
        check("w1c_vs_match", {31'd0, irq}, 32'd1);
        rd(3'd4);
        check("match_kept", dout, 32'd1);

        // Wrap-around does not raise MATCH; the following compare hit does.
        pulse_reset();
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'hFFFF_FFFE);
        wr(3'd0, 32'd1);
        idle(1);
        rd(3'd4);
        check("wrap_no_match", dout, 32'd0);
        rd(3'd3);
        check("wrap_count_zero", dout, 32'd0);
        rd(3'd4);
        check("wrap_then_match", dout, 32'd1);
        rd(3'd3);
        check("nonauto_count", dout, 32'd2);

        // COUNT write on the tick cycle wins and restarts the period.
        pulse_reset();
        wr(3'd1, 32'd3);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd0, 32'd1);
        idle(3);
        wr(3'd3, 32'h100);
        idle(3);
        rd(3'd3);
        check("count_write_wins", dout, 32'h100);
        rd(3'd3);
        check("count_next_inc", dout, 32'h101);
        wr(3'd5, 32'd0);
        rd(3'd5);
        check("capture", dout, 32'h101);

        // Asynchronous reset mid-run.
        pulse_reset();
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd20);
        wr(3'd0, 32'd7);
        idle(50);
        rd(3'd3);
        pulse_reset();
        rd(3'd3);
        check("async_count", dout, 32'd0);
        rd(3'd0);
        check("async_ctrl", dout, 32'd0);
        idle(10);
        rd(3'd3);
        check("async_no_advance", dout, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          e, w;
            logic [2:0]  a;
            logic [31:0] d;
            int          r;
            e = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r < 6)      d = 32'($urandom_range(0, 7));
            else if (r < 8) d = $urandom;
            else            d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (a == 3'd1 && r >= 6) d = 32'($urandom_range(0, 2));
            cyc(e, w, a, d);
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
